hacd_mc_arb: RTL and testbench
==============================

Name: hacd_mc_arb

Overview:
- Shares the single memory-controller request channel between two requesters: CPU pass-through (req 0) and the HACD compression engine (req 1).
- Sits between hacd_core's internal request sources and the MC request port.
- Sequences one transaction at a time: arbitrate, issue, wait for completion.
- Arbitration mode comes from the HACD control register: round-robin, or CPU-priority with aging so the engine cannot starve.

Parameters:
- ADDR_W, 64, request address width.
- LEN_W, 8, burst length field width (beats minus 1).
- AGE_LIMIT, 16, cycles a waiting engine request tolerates in CPU-priority mode before it is forced next; legal 1..255.
- TMO_LIMIT, 1024, cycles allowed in WAIT before timeout; legal 2..65535.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- prio_mode_i  in  1  0 = round-robin, 1 = CPU priority with aging (hacd_ctrl bit 2)
- r0_valid_i  in  1  CPU request valid
- r0_ready_o  out  1  CPU request accepted
- r0_addr_i  in  ADDR_W  CPU address
- r0_len_i  in  LEN_W  CPU burst length
- r0_write_i  in  1  CPU request is a write
- r1_valid_i, r1_ready_o, r1_addr_i, r1_len_i, r1_write_i  same as r0, for the engine
- m_valid_o  out  1  MC request valid
- m_ready_i  in  1  MC accepts request
- m_addr_o  out  ADDR_W  issued address
- m_len_o  out  LEN_W  issued length
- m_write_o  out  1  issued direction
- m_src_o  out  1  issued source id (0 = CPU, 1 = engine)
- m_done_i  in  1  single-cycle pulse: MC finished the current transaction (last read beat or write response)
- busy_o  out  1  high whenever the state is not IDLE
- tmo_o  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last = 1, so the first round-robin grant goes to CPU; age_cnt = 0; tmo_cnt = 0.
- Interface: one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- States:
  - IDLE: if any rN_valid_i, pick a winner, latch its addr/len/write/src into holding registers, pulse rN_ready_o for the winner in the same cycle, go to ISSUE. Requests are consumed at grant, not at m_ready_i.
  - ISSUE: m_valid_o = 1 driving the latched fields, held stable until m_ready_i. On m_ready_i go to WAIT and clear tmo_cnt.
  - WAIT: tmo_cnt increments every cycle.
    - m_done_i → IDLE.
    - tmo_cnt == TMO_LIMIT-1 without m_done_i → pulse tmo_o, go to IDLE.
  - m_done_i outside WAIT is ignored.
- Latency: request valid in IDLE → m_valid_o asserted the next cycle. Minimum 3 cycles per transaction (IDLE, ISSUE, WAIT). No new grant is made until the state returns to IDLE.
- Round-robin (prio_mode_i = 0):
  - Only one requester valid: that requester wins.
  - Both valid: the one not equal to rr_last wins.
  - rr_last updates on every grant.
- CPU priority (prio_mode_i = 1):
  - age_cnt increments each cycle r1_valid_i = 1 and r1 is not granted, saturating at AGE_LIMIT.
  - age_cnt clears when r1 is granted or r1_valid_i = 0.
  - Both valid: r1 wins if age_cnt == AGE_LIMIT, otherwise r0 wins.
  - rr_last still updates on every grant.
- prio_mode_i is sampled only in IDLE; a change mid-transaction takes effect at the next arbitration.
- Requesters must hold valid and payload stable until ready; the arbiter does not check this.
- Reset mid-transaction: return to IDLE immediately, drop the held transaction, m_valid_o = 0.

Decomposition:
- hacd_pkg gets:
  - enum arb_state_e {IDLE, ISSUE, WAIT}
  - typedef mc_req_t {addr, len, write, src}
  - localparams SRC_CPU = 0, SRC_ENG = 1
- One sub-module, hacd_arb_pick: combinational winner select from valids, mode, rr_last and an age_sat flag. Counters and the FSM stay in hacd_mc_arb.

Test Plan:
- CPU-only: r0 addr 0x1000 len 3 write; m_ready_i 1 cycle later; m_done_i 4 cycles after that → m_addr_o = 0x1000, m_src_o = 0, r0_ready_o one pulse, busy_o low the cycle after done.
- Round-robin: both valid continuously for 4 transactions → grant order CPU, ENG, CPU, ENG.
- Aging: prio_mode_i = 1, AGE_LIMIT = 4, both valid continuously → CPU granted repeatedly until age_cnt hits 4, then ENG granted once, then CPU again.
- Timeout: TMO_LIMIT = 8, no m_done_i after accept → tmo_o pulses exactly 8 cycles after the m_ready_i handshake, then IDLE and the next request is granted.
- Backpressure: m_ready_i held low for 10 cycles → m_valid_o and m_addr_o stable throughout; a second requester is not granted.
- Reset in WAIT: rst_ni low 1 cycle → all outputs 0, state IDLE, a pending r1 is granted after reset release.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared types and constants for the HACD memory-controller arbiter.
package hacd_pkg;

  // Default widths of the MC request channel.
  localparam int HACD_ADDR_W = 64;
  localparam int HACD_LEN_W  = 8;

  // Requester ids as they appear on m_src_o and in rr_last.
  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_ENG = 1'b1;

  // Arbiter sequencing: one transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // One MC request at the default channel widths.
  typedef struct packed {
    logic [HACD_ADDR_W-1:0] addr;
    logic [HACD_LEN_W-1:0]  len;
    logic                   write;
    logic                   src;
  } mc_req_t;

endpackage

// File: rtl/hacd_arb_pick.sv
// Combinational winner select between the CPU (0) and engine (1) requesters.
// At most one grant is ever high; no grant without a matching valid.
module hacd_arb_pick
  import hacd_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic prio_mode,
  input  logic rr_last,
  input  logic age_sat,
  output logic grant0,
  output logic grant1
);

  logic eng_wins;

  // Contention is resolved by round-robin or by CPU priority with an aging override.
  always_comb begin
    eng_wins = 1'b0;
    if (valid0 && valid1) begin
      if (prio_mode) begin
        eng_wins = age_sat;
      end else begin
        eng_wins = (rr_last == SRC_CPU);
      end
    end else begin
      eng_wins = valid1;
    end
  end

  assign grant1 = eng_wins;
  assign grant0 = valid0 & ~eng_wins;

endmodule

// File: rtl/hacd_mc_arb.sv
// Shares the single MC request channel between CPU pass-through (req 0) and
// the HACD compression engine (req 1), one transaction at a time.
//
// Handshakes: a requester transfer happens on a rising clock edge where
// rN_valid_i && rN_ready_o; the MC transfer happens on a rising edge where
// m_valid_o && m_ready_i. Requesters hold valid and payload until ready;
// m_valid_o and its payload are held stable until m_ready_i. rN_ready_o is
// only ever high in IDLE, for the single arbitration winner.
module hacd_mc_arb
  import hacd_pkg::*;
#(
  parameter int ADDR_W    = HACD_ADDR_W,
  parameter int LEN_W     = HACD_LEN_W,
  parameter int AGE_LIMIT = 16,
  parameter int TMO_LIMIT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prio_mode_i,
  input  logic              r0_valid_i,
  output logic              r0_ready_o,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [LEN_W-1:0]  r0_len_i,
  input  logic              r0_write_i,
  input  logic              r1_valid_i,
  output logic              r1_ready_o,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [LEN_W-1:0]  r1_len_i,
  input  logic              r1_write_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [LEN_W-1:0]  m_len_o,
  output logic              m_write_o,
  output logic              m_src_o,
  input  logic              m_done_i,
  output logic              busy_o,
  output logic              tmo_o,
  output arb_state_e        state_o
);

  localparam int AGE_W = 8;
  localparam int TMO_W = 16;

  // Held copy of the granted request, driven onto the MC channel.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              write;
    logic              src;
  } hold_t;

  arb_state_e       state;
  hold_t            hold;
  logic             m_valid_q;
  logic             busy_q;
  logic             tmo_q;
  logic             rr_last;
  logic [AGE_W-1:0] age_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             age_sat;
  logic             pick0;
  logic             pick1;
  logic             in_idle;

  assign age_sat = (age_cnt == AGE_W'(AGE_LIMIT));
  assign in_idle = (state == IDLE);

  hacd_arb_pick u_pick (
    .valid0    (r0_valid_i),
    .valid1    (r1_valid_i),
    .prio_mode (prio_mode_i),
    .rr_last   (rr_last),
    .age_sat   (age_sat),
    .grant0    (pick0),
    .grant1    (pick1)
  );

  // Requests are consumed at grant; rst_ni gating keeps ready low during reset.
  assign r0_ready_o = in_idle & pick0 & rst_ni;
  assign r1_ready_o = in_idle & pick1 & rst_ni;

  assign m_valid_o = m_valid_q;
  assign m_addr_o  = hold.addr;
  assign m_len_o   = hold.len;
  assign m_write_o = hold.write;
  assign m_src_o   = hold.src;
  assign busy_o    = busy_q;
  assign tmo_o     = tmo_q;
  assign state_o   = state;

  // Transaction sequencer: grant in IDLE, present in ISSUE, await completion in WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      hold      <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      rr_last   <= SRC_ENG;
      tmo_cnt   <= '0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick0 || pick1) begin
            if (pick1) begin
              hold <= '{addr: r1_addr_i, len: r1_len_i, write: r1_write_i, src: SRC_ENG};
              rr_last <= SRC_ENG;
            end else begin
              hold <= '{addr: r0_addr_i, len: r0_len_i, write: r0_write_i, src: SRC_CPU};
              rr_last <= SRC_CPU;
            end
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (m_done_i) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (tmo_cnt == TMO_W'(TMO_LIMIT - 1)) begin
            tmo_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Engine wait age: counts every cycle the engine waits ungranted, saturating;
  // only consulted by the picker in CPU-priority mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_cnt <= '0;
    end else if (!r1_valid_i || r1_ready_o) begin
      age_cnt <= '0;
    end else if (!age_sat) begin
      age_cnt <= age_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hacd_mc_arb.sv
// Directed bench for hacd_mc_arb: requester drivers, an MC responder model,
// a grant scoreboard fed from the test sequence, and targeted timing checks.
module tb_hacd_mc_arb;
  import hacd_pkg::*;

  localparam int ADDR_W    = 64;
  localparam int LEN_W     = 8;
  localparam int AGE_LIMIT = 4;
  localparam int TMO_LIMIT = 8;
  localparam int EXP_W     = 2 + LEN_W + ADDR_W;
  localparam int PL_W      = 1 + LEN_W + ADDR_W;

  logic              clk_i;
  logic              rst_ni;
  logic              prio_mode_i;
  logic              r0_valid_i, r0_ready_o, r0_write_i;
  logic [ADDR_W-1:0] r0_addr_i;
  logic [LEN_W-1:0]  r0_len_i;
  logic              r1_valid_i, r1_ready_o, r1_write_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [LEN_W-1:0]  r1_len_i;
  logic              m_valid_o, m_ready_i, m_write_o, m_src_o, m_done_i;
  logic [ADDR_W-1:0] m_addr_o;
  logic [LEN_W-1:0]  m_len_o;
  logic              busy_o, tmo_o;
  arb_state_e        state_o;

  hacd_mc_arb #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .AGE_LIMIT (AGE_LIMIT),
    .TMO_LIMIT (TMO_LIMIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .prio_mode_i (prio_mode_i),
    .r0_valid_i  (r0_valid_i),
    .r0_ready_o  (r0_ready_o),
    .r0_addr_i   (r0_addr_i),
    .r0_len_i    (r0_len_i),
    .r0_write_i  (r0_write_i),
    .r1_valid_i  (r1_valid_i),
    .r1_ready_o  (r1_ready_o),
    .r1_addr_i   (r1_addr_i),
    .r1_len_i    (r1_len_i),
    .r1_write_i  (r1_write_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_addr_o    (m_addr_o),
    .m_len_o     (m_len_o),
    .m_write_o   (m_write_o),
    .m_src_o     (m_src_o),
    .m_done_i    (m_done_i),
    .busy_o      (busy_o),
    .tmo_o       (tmo_o),
    .state_o     (state_o)
  );

  logic [EXP_W-1:0] exp_q[$];
  logic [PL_W-1:0]  r0_q[$];
  logic [PL_W-1:0]  r1_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rdy_dly  = 1;
  int done_dly = 1;
  int hs_cyc   = 0;
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;
  int tmo_pulses = 0;

  // Clock and cycle counter.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_outs"},
          EXP_W'({r0_ready_o, r1_ready_o, m_valid_o, m_addr_o, m_len_o,
                  m_write_o, m_src_o, busy_o, tmo_o}), '0);
    check({name, "_state"}, EXP_W'(state_o), EXP_W'(IDLE));
  endtask

  task automatic push_req(input logic src, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input logic write);
    if (src) r1_q.push_back({write, len, addr});
    else     r0_q.push_back({write, len, addr});
  endtask

  task automatic push_exp(input logic src, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input logic write);
    exp_q.push_back({src, write, len, addr});
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(negedge clk_i);
    check_zero("reset");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && r0_q.size() == 0 && r1_q.size() == 0 && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drain"}, EXP_W'(ok), EXP_W'(1));
  endtask

  // CPU requester driver: presents queue head, pops on handshake.
  initial begin
    bit hs;
    r0_valid_i = 1'b0; r0_addr_i = '0; r0_len_i = '0; r0_write_i = 1'b0;
    forever begin
      @(negedge clk_i);
      hs = r0_valid_i && r0_ready_o;
      @(posedge clk_i); #1;
      if (hs) void'(r0_q.pop_front());
      if (r0_q.size() > 0) begin
        {r0_write_i, r0_len_i, r0_addr_i} = r0_q[0];
        r0_valid_i = 1'b1;
      end else begin
        r0_valid_i = 1'b0;
      end
    end
  end

  // Engine requester driver.
  initial begin
    bit hs;
    r1_valid_i = 1'b0; r1_addr_i = '0; r1_len_i = '0; r1_write_i = 1'b0;
    forever begin
      @(negedge clk_i);
      hs = r1_valid_i && r1_ready_o;
      @(posedge clk_i); #1;
      if (hs) void'(r1_q.pop_front());
      if (r1_q.size() > 0) begin
        {r1_write_i, r1_len_i, r1_addr_i} = r1_q[0];
        r1_valid_i = 1'b1;
      end else begin
        r1_valid_i = 1'b0;
      end
    end
  end

  // MC responder: ready after rdy_dly valid cycles, done in the done_dly-th
  // WAIT cycle (done_dly = 0 never completes).
  initial begin
    bit hs_pend, in_wait;
    int vcnt, wcnt;
    hs_pend = 0; in_wait = 0; vcnt = 0; wcnt = 0;
    m_ready_i = 1'b0; m_done_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      m_done_i = 1'b0;
      if (!rst_ni) begin
        hs_pend = 0; in_wait = 0; vcnt = 0; m_ready_i = 1'b0;
      end else begin
        if (hs_pend) begin hs_pend = 0; in_wait = 1; wcnt = 0; end
        if (in_wait) begin
          wcnt++;
          if (done_dly > 0 && wcnt == done_dly) begin m_done_i = 1'b1; in_wait = 0; end
        end
        if (m_valid_o) begin
          if (vcnt >= rdy_dly) begin m_ready_i = 1'b1; hs_pend = 1; vcnt = 0; end
          else begin m_ready_i = 1'b0; vcnt++; end
        end else begin
          m_ready_i = 1'b0; vcnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor: every MC handshake must match the next expected grant.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (m_valid_o && m_ready_i) begin
          hs_cyc = cyc + 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got %0h expected none",
                     {m_src_o, m_write_o, m_len_o, m_addr_o});
          end else begin
            e = exp_q.pop_front();
            check("grant", {m_src_o, m_write_o, m_len_o, m_addr_o}, e);
          end
        end
        if (r0_ready_o || r1_ready_o) check("one_ready", EXP_W'(r0_ready_o & r1_ready_o), '0);
        if (r0_ready_o) rdy0_cnt++;
        if (r1_ready_o) rdy1_cnt++;
        if (tmo_o) tmo_pulses++;
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Test sequence.
  initial begin
    int base0, base1, base_t;
    bit seen;
    rst_ni = 1'b0; prio_mode_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_zero("por");
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);

    // CPU-only transaction.
    base0 = rdy0_cnt; rdy_dly = 1; done_dly = 4;
    push_req(0, 64'h1000, 8'd3, 1'b1); push_exp(0, 64'h1000, 8'd3, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); if (r0_ready_o) begin seen = 1; break; end end
    check("cpu_ready_seen", EXP_W'(seen), EXP_W'(1));
    @(negedge clk_i);
    check("cpu_issue", EXP_W'({m_valid_o, m_src_o, busy_o, m_addr_o}), EXP_W'({1'b1, 1'b0, 1'b1, 64'h1000}));
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); if (m_done_i) begin seen = 1; break; end end
    check("cpu_done_seen", EXP_W'(seen), EXP_W'(1));
    @(negedge clk_i);
    check("cpu_busy_low", EXP_W'({busy_o, state_o}), EXP_W'({1'b0, IDLE}));
    wait_drain("cpu", 50);
    check("cpu_ready_pulses", EXP_W'(rdy0_cnt - base0), EXP_W'(1));

    // Round-robin under continuous contention.
    do_reset();
    base0 = rdy0_cnt; base1 = rdy1_cnt; rdy_dly = 0; done_dly = 1;
    push_req(0, 64'h2000, 8'd1, 1'b0); push_req(0, 64'h2040, 8'd2, 1'b1);
    push_req(1, 64'h8000, 8'd7, 1'b1); push_req(1, 64'h8100, 8'd15, 1'b0);
    push_exp(0, 64'h2000, 8'd1, 1'b0); push_exp(1, 64'h8000, 8'd7, 1'b1);
    push_exp(0, 64'h2040, 8'd2, 1'b1); push_exp(1, 64'h8100, 8'd15, 1'b0);
    wait_drain("rr", 100);
    check("rr_ready_counts", EXP_W'({16'(rdy0_cnt - base0), 16'(rdy1_cnt - base1)}), EXP_W'({16'd2, 16'd2}));

    // CPU priority with aging (3-cycle transactions, AGE_LIMIT 4).
    do_reset();
    prio_mode_i = 1'b1;
    push_req(0, 64'h3000, 8'd0, 1'b0); push_req(0, 64'h3010, 8'd0, 1'b0);
    push_req(0, 64'h3020, 8'd0, 1'b0); push_req(0, 64'h3030, 8'd0, 1'b0);
    push_req(1, 64'hA000, 8'd3, 1'b1); push_req(1, 64'hA010, 8'd3, 1'b1);
    push_exp(0, 64'h3000, 8'd0, 1'b0); push_exp(0, 64'h3010, 8'd0, 1'b0);
    push_exp(1, 64'hA000, 8'd3, 1'b1); push_exp(0, 64'h3020, 8'd0, 1'b0);
    push_exp(1, 64'hA010, 8'd3, 1'b1); push_exp(0, 64'h3030, 8'd0, 1'b0);
    wait_drain("age", 100);
    @(negedge clk_i);
    prio_mode_i = 1'b0;

    // WAIT timeout, then the pending engine request is granted.
    do_reset();
    base_t = tmo_pulses; rdy_dly = 1; done_dly = 0;
    push_req(0, 64'h5000, 8'd4, 1'b0); push_req(1, 64'hB000, 8'd5, 1'b1);
    push_exp(0, 64'h5000, 8'd4, 1'b0); push_exp(1, 64'hB000, 8'd5, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk_i); if (tmo_o) begin seen = 1; break; end end
    check("tmo_seen", EXP_W'(seen), EXP_W'(1));
    check("tmo_latency", EXP_W'(cyc - hs_cyc), EXP_W'(TMO_LIMIT));
    check("tmo_next_grant", EXP_W'({state_o, r1_ready_o, busy_o}), EXP_W'({IDLE, 1'b1, 1'b0}));
    done_dly = 2;
    wait_drain("tmo", 50);
    check("tmo_pulses", EXP_W'(tmo_pulses - base_t), EXP_W'(1));

    // Backpressure: ISSUE payload held, second requester not granted.
    do_reset();
    base1 = rdy1_cnt; rdy_dly = 10; done_dly = 2;
    push_req(0, 64'h4000, 8'd7, 1'b0); push_exp(0, 64'h4000, 8'd7, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); if (m_valid_o) begin seen = 1; break; end end
    check("bp_valid_seen", EXP_W'(seen), EXP_W'(1));
    push_req(1, 64'hC000, 8'd1, 1'b1); push_exp(1, 64'hC000, 8'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", EXP_W'({m_valid_o, r1_ready_o, m_len_o, m_addr_o}),
            EXP_W'({1'b1, 1'b0, 8'd7, 64'h4000}));
      @(negedge clk_i);
    end
    wait_drain("bp", 100);
    check("bp_eng_granted", EXP_W'(rdy1_cnt - base1), EXP_W'(1));

    // Reset while in WAIT drops the transaction; pending engine is granted after.
    rdy_dly = 1; done_dly = 0;
    push_req(0, 64'h6000, 8'd2, 1'b1); push_req(1, 64'hD000, 8'd9, 1'b0);
    push_exp(0, 64'h6000, 8'd2, 1'b1); push_exp(1, 64'hD000, 8'd9, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk_i); if (state_o == WAIT) begin seen = 1; break; end end
    check("rstw_wait_seen", EXP_W'(seen), EXP_W'(1));
    do_reset();
    done_dly = 2;
    seen = (r1_ready_o === 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk_i); if (r1_ready_o) seen = 1; end
    check("rstw_eng_granted", EXP_W'(seen), EXP_W'(1));
    wait_drain("rstw", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
